// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: set-2 digit scancodes, frame geometry
// and the transmit FSM state type.
package ps2_pkg;

  localparam logic [7:0] SC_0 = 8'h45;
  localparam logic [7:0] SC_1 = 8'h16;
  localparam logic [7:0] SC_2 = 8'h1E;
  localparam logic [7:0] SC_3 = 8'h26;
  localparam logic [7:0] SC_4 = 8'h25;
  localparam logic [7:0] SC_5 = 8'h2E;
  localparam logic [7:0] SC_6 = 8'h36;
  localparam logic [7:0] SC_7 = 8'h3D;
  localparam logic [7:0] SC_8 = 8'h3E;
  localparam logic [7:0] SC_9 = 8'h46;

  localparam logic [7:0] SC_BREAK = 8'hF0;

  localparam int FRAME_BITS = 11;
  localparam logic [3:0] STOP_IDX = 4'd10;
  localparam logic [3:0] GAP_IDX  = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP
  } tx_state_e;

  typedef struct packed {
    logic       ok;
    logic [7:0] code;
  } sc_t;

  function automatic sc_t digit_to_scancode(input logic [3:0] d);
    sc_t r;
    r.ok = 1'b1;
    case (d)
      4'd0:    r.code = SC_0;
      4'd1:    r.code = SC_1;
      4'd2:    r.code = SC_2;
      4'd3:    r.code = SC_3;
      4'd4:    r.code = SC_4;
      4'd5:    r.code = SC_5;
      4'd6:    r.code = SC_6;
      4'd7:    r.code = SC_7;
      4'd8:    r.code = SC_8;
      4'd9:    r.code = SC_9;
      default: begin
        r.code = 8'h00;
        r.ok   = 1'b0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_frame_tx.sv
// Single-byte PS/2 device-to-host serializer: 11 bit cells
// followed by one idle gap cell, odd parity generated here.
module ps2_frame_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       frame_end,
  output logic       done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0]         cnt;
  logic                  low_half;
  logic [3:0]            bit_idx;
  logic [FRAME_BITS-1:0] frame;
  logic                  running;
  logic                  half_end;
  logic                  cell_end;

  assign half_end  = running && (cnt == CNT_MAX);
  assign cell_end  = half_end && low_half;
  assign frame_end = cell_end && (bit_idx == STOP_IDX);
  assign done      = cell_end && (bit_idx == GAP_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      cnt      <= '0;
      low_half <= 1'b0;
      bit_idx  <= '0;
      frame    <= '1;
      running  <= 1'b0;
    end else if (start) begin
      frame    <= {1'b1, ~^byte_in, byte_in, 1'b0};
      ps2_data <= 1'b0;
      ps2_clk  <= 1'b1;
      cnt      <= '0;
      low_half <= 1'b0;
      bit_idx  <= '0;
      running  <= 1'b1;
    end else if (running) begin
      if (!half_end) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
        if (!low_half) begin
          low_half <= 1'b1;
          // the gap cell keeps the clock line parked high
          ps2_clk  <= (bit_idx == GAP_IDX);
        end else begin
          low_half <= 1'b0;
          ps2_clk  <= 1'b1;
          if (bit_idx == GAP_IDX) begin
            running <= 1'b0;
            bit_idx <= '0;
          end else begin
            bit_idx  <= bit_idx + 4'd1;
            frame    <= {1'b1, frame[FRAME_BITS-1:1]};
            ps2_data <= frame[1];
          end
        end
      end
    end
  end

endmodule

// File: rtl/ps2_digit_tx.sv
// Digit-to-PS/2 keyboard emulator: handshake, code map and
// make/break byte sequencing around ps2_frame_tx.
module ps2_digit_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 8,
  parameter bit SEND_BREAK = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  output logic       digit_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       err
);

  localparam logic [1:0] LAST_IDX = SEND_BREAK ? 2'd2 : 2'd0;

  tx_state_e  state;
  logic [7:0] code;
  logic [1:0] idx;
  sc_t        sc;
  logic       start;
  logic [7:0] tx_byte;
  logic       frame_end;
  logic       done;

  assign sc      = digit_to_scancode(digit);
  assign start   = (state == ST_LOAD);
  assign tx_byte = (idx == 2'd1) ? SC_BREAK : code;

  ps2_frame_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_frame (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .byte_in   (tx_byte),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .frame_end (frame_end),
    .done      (done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      code        <= '0;
      idx         <= '0;
      digit_ready <= 1'b1;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (digit_valid && digit_ready) begin
            if (sc.ok) begin
              code        <= sc.code;
              idx         <= '0;
              state       <= ST_LOAD;
              digit_ready <= 1'b0;
              busy        <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_LOAD: state <= ST_SHIFT;
        ST_SHIFT: begin
          if (frame_end) state <= ST_GAP;
        end
        ST_GAP: begin
          if (done) begin
            if (idx == LAST_IDX) begin
              state       <= ST_IDLE;
              digit_ready <= 1'b1;
              busy        <= 1'b0;
            end else begin
              idx   <= idx + 2'd1;
              state <= ST_LOAD;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/ps2_digit_tx.md
# ps2_digit_tx

Transmit-side counterpart to the PS/2 scancode-to-digit decoder. Accepts a decimal digit over a valid/ready handshake and maps it to its PS/2 set-2 make code. It then serializes the code as a device-to-host PS/2 frame on generated `ps2_clk`/`ps2_data` lines, optionally followed by the break sequence (`F0`, code). It sits in the keyboard-emulation path of the bench/SoC and drives the decoder side directly.

## Interface
- `CLK_DIV`, default 8: system clocks per PS/2 clock half-period; legal values are 2 or more.
- `SEND_BREAK`, default 1: 1 = send make, `F0`, make; 0 = send make only.
- `clk` input 1: system clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `digit` input 4: digit to send, 0-9.
- `digit_valid` input 1: `digit` is valid.
- `digit_ready` output 1: block is idle and can accept a digit.
- `ps2_clk` output 1: generated PS/2 clock; idles high.
- `ps2_data` output 1: PS/2 data; idles high.
- `busy` output 1: a sequence is in progress.
- `err` output 1: one-cycle pulse when an out-of-range digit is accepted.

## Operation
- **Code map** (same as decoder): 0→45, 1→16, 2→1E, 3→26, 4→25, 5→2E, 6→36, 7→3D, 8→3E, 9→46 (hex).
- **Handshake**
  - `digit_ready` = 1 only in IDLE.
  - A transfer occurs on an edge where `digit_valid && digit_ready`.
  - `digit` is latched at that edge; later changes to `digit` are ignored.
- **Digit 10-15**
  - Accepted, `err` = 1 for the next cycle, nothing transmitted.
  - Block stays IDLE; `digit_ready` stays 1.
- **FSM states**
  - IDLE → LOAD on a valid transfer.
  - LOAD → SHIFT: selects the byte for the current sequence index.
  - SHIFT: bit index 0..10, one bit cell per bit. After index 10 completes → GAP.
  - GAP: idle lines for one bit cell. Then → LOAD if bytes remain in the sequence, else → IDLE.
- **Byte sequence**
  - `SEND_BREAK`=0: one byte, the make code.
  - `SEND_BREAK`=1: three bytes, make, `F0`, make.
- **Frame**: 11 bits in this order.
  - Start bit 0.
  - Data bits d0..d7, LSB first.
  - Odd parity bit = ~^byte.
  - Stop bit 1.
- **Bit cell**: 2·`CLK_DIV` cycles.
  - `ps2_clk` = 1 for the first `CLK_DIV` cycles, then 0 for `CLK_DIV` cycles.
  - `ps2_data` changes only on the first cycle of the high phase; it is stable across the falling edge, where the receiver samples.
- **Registers**: all outputs are registered; no combinational path from inputs to `ps2_*`.
- **`busy`**: 1 from the cycle after acceptance of a valid digit until return to IDLE. `busy` is the exact complement of `digit_ready`, except during an `err` cycle.

## Timing
- **Reset values**: `ps2_clk`=1, `ps2_data`=1, `busy`=0, `err`=0, `digit_ready`=1 (IDLE). Bit and cycle counters are 0.
- **Acceptance at edge T**
  - LOAD occupies one cycle at T+1.
  - Start bit appears at T+2 with `ps2_clk` high.
  - First `ps2_clk` fall at T+2+`CLK_DIV`.
- **Sequence length**: each byte takes 11 cells plus 1 gap cell, i.e. 24·`CLK_DIV` cycles, plus 1 LOAD cycle.
  - `SEND_BREAK`=0: `digit_ready` returns at T+2+24·`CLK_DIV`.
  - `SEND_BREAK`=1: `digit_ready` returns at T+4+72·`CLK_DIV`.
- **Back-to-back**: `digit_valid` held high is honored on the first edge with `digit_ready`=1. The next start bit follows after that LOAD cycle, so a minimum of one idle gap cell always separates frames.
- **Reset mid-frame**: on the asynchronous assertion, `ps2_clk`/`ps2_data` go high immediately and the frame is abandoned. After release the block is IDLE; no partial frame resumes.
- **`CLK_DIV` counter**: wraps at `CLK_DIV`-1. The counter width is $clog2(`CLK_DIV`).

## Structure
- **Package `ps2_pkg`**
  - Scancode constants `SC_0`..`SC_9`.
  - `SC_BREAK` = 8'hF0.
  - Frame length constant 11.
  - Function `digit_to_scancode` (returns code and an in-range flag).
  - FSM state enum.
  - Shared with the decoder.
- **Sub-module `ps2_frame_tx`**
  - Single-byte serializer with `start`/`byte_in`/`done`, owning the bit-cell timing and parity.
  - `ps2_digit_tx` owns the handshake, code map and byte-sequence FSM.

## Test plan
- **Make-only frame**: `CLK_DIV`=4, `SEND_BREAK`=0, digit 0.
  - `ps2_data` sampled on `ps2_clk` falls = 0,1,0,1,0,0,0,1,0,0,1.
  - Exactly 11 falls; `digit_ready` back after 96+2 cycles.
- **Make plus break**: `SEND_BREAK`=1, digit 9.
  - Three frames decode to 46, F0, 46, with parity bits 0, 1, 0.
  - Gap between frames ≥ 8 cycles with both lines high.
- **Full map**: all digits 0-9 sent into the PS/2 decoder; the decoder reports `out` = digit and `valid` = 1 for each make code.
- **Out-of-range digit**: digit 12.
  - `err` high exactly one cycle, zero `ps2_clk` falls, `digit_ready` never drops.
- **Back-to-back**: `digit_valid` held high with digit 1, switched to 2 during the first sequence. Sent codes are 16 then 1E, and 2 is accepted only when `digit_ready`=1.
- **Reset mid-frame**: `rst_n` asserted low during data bit 4.
  - Both lines high in the same timestep; `busy`=0.
  - After release, a new digit 5 produces a clean 2E frame.
